// File: rtl/snoop_resp.sv
// rtl/snoop_resp.sv - snoop responder: tag/state table lookup, Modified-block writeback and state downgrade.
// Optional feature macro: SNOOP_STATS_EN adds saturating snoop_hits / snoop_wbs counters.
module snoop_resp (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        ccwrite,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    output logic [2:0]  rd_idx,
    output logic        rd_word,
    input  logic [31:0] rd_data,
    input  logic        upd_en,
    input  logic [2:0]  upd_idx,
    input  logic [25:0] upd_tag,
    input  logic [1:0]  upd_state,
`ifdef SNOOP_STATS_EN
    output logic [15:0] snoop_hits,
    output logic [15:0] snoop_wbs,
`endif
    output logic        snoop_busy
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB0    = 3'd2,
        WB1    = 3'd3,
        UPD    = 3'd4,
        DONE   = 3'd5
    } fsm_t;

    fsm_t        r_fsm;
    fsm_t        w_fsm_nxt;

    logic [25:0] r_tag [8];
    logic [1:0]  r_st  [8];
    logic [31:3] r_addr;
    logic        r_inv;
    logic        r_hit;
    logic        r_hit_m;

    logic [2:0]  w_lk_idx;
    logic        w_lk_valid;
    logic        w_lk_hit;
    logic        w_lk_hit_m;
    logic        w_in_wb;
    logic        w_unused_low;

    // Byte offset and word select of the snoop address never reach the table.
    assign w_unused_low = ^ccsnoopaddr[2:0];

    assign w_lk_idx   = ccsnoopaddr[5:3];
    assign w_lk_valid = (r_st[w_lk_idx] == ST_S) || (r_st[w_lk_idx] == ST_M);
    assign w_lk_hit   = w_lk_valid && (r_tag[w_lk_idx] == ccsnoopaddr[31:6]);
    assign w_lk_hit_m = w_lk_hit && (r_st[w_lk_idx] == ST_M);
    assign w_in_wb    = (r_fsm == WB0) || (r_fsm == WB1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        ccwrite    = 1'b0;
        dWEN       = 1'b0;
        rd_word    = 1'b0;
        rd_idx     = 3'd0;
        daddr      = 32'd0;
        dstore     = 32'd0;
        snoop_busy = 1'b1;
        case (r_fsm)
            IDLE: begin
                snoop_busy = ccwait;
                if (ccwait) begin
                    w_fsm_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                ccwrite = w_lk_hit_m;
                if (!ccwait) begin
                    w_fsm_nxt = IDLE;
                end else if (w_lk_hit_m) begin
                    w_fsm_nxt = WB0;
                end else begin
                    w_fsm_nxt = UPD;
                end
            end
            WB0: begin
                if (!dwait) begin
                    w_fsm_nxt = WB1;
                end
            end
            WB1: begin
                rd_word = 1'b1;
                if (!dwait) begin
                    w_fsm_nxt = UPD;
                end
            end
            UPD: begin
                w_fsm_nxt = DONE;
            end
            DONE: begin
                // Hold here until the controller releases ccwait so one request is serviced once.
                if (!ccwait) begin
                    w_fsm_nxt = IDLE;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
        if (w_in_wb) begin
            ccwrite = 1'b1;
            dWEN    = 1'b1;
            rd_idx  = r_addr[5:3];
            daddr   = {r_addr[31:3], rd_word, 2'b00};
            dstore  = rd_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                r_tag[i] <= '0;
                r_st[i]  <= ST_I;
            end
        end else if ((r_fsm == IDLE) && !ccwait && upd_en) begin
            r_tag[upd_idx] <= upd_tag;
            r_st[upd_idx]  <= upd_state;
        end else if ((r_fsm == UPD) && r_hit) begin
            if (r_inv) begin
                r_st[r_addr[5:3]] <= ST_I;
            end else if (r_hit_m) begin
                r_st[r_addr[5:3]] <= ST_S;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr  <= '0;
            r_inv   <= 1'b0;
            r_hit   <= 1'b0;
            r_hit_m <= 1'b0;
        end else if ((r_fsm == LOOKUP) && ccwait) begin
            r_addr  <= ccsnoopaddr[31:3];
            r_inv   <= ccinv;
            r_hit   <= w_lk_hit;
            r_hit_m <= w_lk_hit_m;
        end
    end

`ifdef SNOOP_STATS_EN
    logic [15:0] r_hits;
    logic [15:0] r_wbs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hits <= '0;
            r_wbs  <= '0;
        end else begin
            if ((r_fsm == LOOKUP) && ccwait && w_lk_hit && (r_hits != 16'hFFFF)) begin
                r_hits <= r_hits + 16'd1;
            end
            if ((r_fsm == WB1) && !dwait && (r_wbs != 16'hFFFF)) begin
                r_wbs <= r_wbs + 16'd1;
            end
        end
    end

    assign snoop_hits = r_hits;
    assign snoop_wbs  = r_wbs;
`endif

endmodule

// File: tb/tb_snoop_resp.sv
// tb/tb_snoop_resp.sv - scoreboard bench for snoop_resp with randomized snoops and table updates.
module tb_snoop_resp;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ccwait = 1'b0;
    logic        ccinv = 1'b0;
    logic [31:0] ccsnoopaddr = 32'd0;
    logic        ccwrite;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait = 1'b0;
    logic [2:0]  rd_idx;
    logic        rd_word;
    logic [31:0] rd_data;
    logic        upd_en = 1'b0;
    logic [2:0]  upd_idx = 3'd0;
    logic [25:0] upd_tag = 26'd0;
    logic [1:0]  upd_state = 2'd0;
    logic        snoop_busy;
`ifdef SNOOP_STATS_EN
    logic [15:0] snoop_hits;
    logic [15:0] snoop_wbs;
`endif

    snoop_resp dut (
        .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ccwrite(ccwrite), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait),
        .rd_idx(rd_idx), .rd_word(rd_word), .rd_data(rd_data),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_tag(upd_tag), .upd_state(upd_state),
`ifdef SNOOP_STATS_EN
        .snoop_hits(snoop_hits), .snoop_wbs(snoop_wbs),
`endif
        .snoop_busy(snoop_busy)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [16];
    assign rd_data = mem[{rd_idx, rd_word}];

    // Reference cache: per-index tag and MSI state, stats counts, expected writeback words.
    logic [25:0] m_tag [8];
    logic [1:0]  m_st  [8];
    int          m_hits = 0;
    int          m_wbs  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wb_t;
    wb_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int acc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit m_is_hit(input logic [31:0] a);
        return (m_tag[a[5:3]] == a[31:6]) && (m_st[a[5:3]] == 2'b01 || m_st[a[5:3]] == 2'b10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0;
            m_st[i]  = 2'b00;
        end
        m_hits = 0;
        m_wbs  = 0;
    endtask

    // Monitor: every accepted writeback word is popped and compared.
    always @(negedge CLK) begin
        if (!RST && dWEN && !dwait) begin
            wb_t e;
            acc++;
            chk("wb_ccwrite", {31'd0, ccwrite}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", daddr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wb_daddr", daddr, e.a);
                chk("wb_dstore", dstore, e.d);
            end
        end
    end

    task automatic do_update(input logic [2:0] idx, input logic [25:0] tag, input logic [1:0] st);
        @(posedge CLK); #1;
        upd_en = 1'b1; upd_idx = idx; upd_tag = tag; upd_state = st;
        @(posedge CLK); #1;
        upd_en = 1'b0;
        m_tag[idx] = tag;
        m_st[idx]  = st;
    endtask

    task automatic do_snoop(input logic [31:0] addr, input logic inv, input int stall,
                            input logic with_upd, input int done_hold);
        logic [2:0] idx;
        bit         hit;
        bit         hm;
        int         start;
        int         n;
        wb_t        e;
        idx = addr[5:3];
        hit = m_is_hit(addr);
        hm  = hit && (m_st[idx] == 2'b10);
        if (hm) begin
            e.a = {addr[31:3], 1'b0, 2'b00}; e.d = mem[{idx, 1'b0}]; exp_q.push_back(e);
            e.a = {addr[31:3], 1'b1, 2'b00}; e.d = mem[{idx, 1'b1}]; exp_q.push_back(e);
        end
        @(posedge CLK); #1;
        ccwait = 1'b1; ccsnoopaddr = addr; ccinv = inv;
        dwait = (stall > 0);
        if (with_upd) begin
            upd_en = 1'b1; upd_idx = idx; upd_tag = addr[31:6]; upd_state = 2'b10;
        end
        @(negedge CLK);
        chk("busy_on_ccwait", {31'd0, snoop_busy}, 32'd1);
        @(posedge CLK); #1;
        upd_en = 1'b0;
        @(negedge CLK);
        chk("lookup_ccwrite", {31'd0, ccwrite}, {31'd0, hm});
        chk("lookup_dwen", {31'd0, dWEN}, 32'd0);
        if (hm) begin
            start = acc;
            n     = 0;
            for (int k = 0; k < stall; k++) begin
                @(posedge CLK); #1;
                @(negedge CLK);
                chk("stall_dwen", {31'd0, dWEN}, 32'd1);
                chk("stall_daddr", daddr, {addr[31:3], 3'b000});
                chk("stall_dstore", dstore, mem[{idx, 1'b0}]);
            end
            while ((acc - start) < 2 && n < 100) begin
                @(posedge CLK); #1;
                if ((acc - start) < 2) begin
                    dwait = ($urandom % 3 == 0);
                    upd_en = ($urandom % 4 == 0);
                    upd_idx = idx; upd_tag = addr[31:6]; upd_state = 2'b10;
                end
                n++;
            end
            if ((acc - start) < 2) begin
                chk("wb_timeout", acc - start, 2);
            end
        end else begin
            @(posedge CLK); #1;
        end
        dwait = 1'b0; upd_en = 1'b0;
        @(posedge CLK); #1;
        for (int k = 0; k < done_hold; k++) begin
            @(negedge CLK);
            chk("done_busy", {31'd0, snoop_busy}, 32'd1);
            chk("done_dwen", {31'd0, dWEN}, 32'd0);
            @(posedge CLK); #1;
        end
        ccwait = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("idle_busy", {31'd0, snoop_busy}, 32'd0);
        if (hit) begin
            m_hits++;
            if (inv) m_st[idx] = 2'b00;
            else if (hm) m_st[idx] = 2'b01;
        end
        if (hm) m_wbs++;
    endtask

    logic [25:0] tags [4];

    initial begin
        wb_t e;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        tags[0] = 26'h0; tags[1] = 26'h1; tags[2] = 26'h2; tags[3] = 26'h41;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dwen", {31'd0, dWEN}, 32'd0);
        chk("rst_ccwrite", {31'd0, ccwrite}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_busy", {31'd0, snoop_busy}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
`ifdef SNOOP_STATS_EN
        @(negedge CLK);
        chk("stats_rst_hits", {16'd0, snoop_hits}, 32'd0);
        chk("stats_rst_wbs", {16'd0, snoop_wbs}, 32'd0);
`endif

        // Modified hit without invalidate: two-word writeback then Shared.
        do_update(3'd2, 26'h1, 2'b10);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);
        // Modified hit with invalidate and a five-cycle stall in WB0.
        do_update(3'd2, 26'h1, 2'b10);
        do_snoop(32'h50, 1'b1, 5, 1'b0, 2);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);
        // Shared hit with invalidate; miss leaves a Modified entry alone.
        do_update(3'd2, 26'h1, 2'b01);
        do_snoop(32'h50, 1'b1, 0, 1'b0, 1);
        do_update(3'd2, 26'h1, 2'b10);
        do_snoop(32'h1050, 1'b1, 0, 1'b0, 0);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);
        // Update colliding with ccwait rise is dropped (entry stays Shared).
        do_snoop(32'h50, 1'b0, 0, 1'b1, 0);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {tags[$urandom % 4], 3'($urandom), 3'($urandom)};
            if ($urandom % 10 < 3) begin
                do_update(3'($urandom), tags[$urandom % 4], 2'($urandom));
            end else begin
                do_snoop(a, 1'($urandom), ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0,
                         ($urandom % 8 == 0), int'($urandom % 3));
            end
        end

        chk("queue_drained_pre_rst", exp_q.size(), 0);
        // Reset landing in WB1 aborts the writeback and invalidates the whole table.
        for (int i = 0; i < 8; i++) do_update(3'(i), 26'h0, 2'b10);
        do_update(3'd2, 26'h1, 2'b10);
        e.a = 32'h50; e.d = mem[{3'd2, 1'b0}]; exp_q.push_back(e);
        @(posedge CLK); #1;
        ccwait = 1'b1; ccsnoopaddr = 32'h50; ccinv = 1'b0; dwait = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        dwait = 1'b1;
        @(negedge CLK);
        chk("wb1_daddr", daddr, 32'h54);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; ccwait = 1'b0; dwait = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("abort_dwen", {31'd0, dWEN}, 32'd0);
        chk("abort_ccwrite", {31'd0, ccwrite}, 32'd0);
        chk("abort_daddr", daddr, 32'd0);
        chk("queue_after_abort", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) do_snoop({26'h0, 3'(i), 3'b000}, 1'b0, 0, 1'b0, 0);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);

`ifdef SNOOP_STATS_EN
        do_update(3'd2, 26'h1, 2'b10);
        do_snoop(32'h50, 1'b0, 0, 1'b0, 0);
        do_update(3'd2, 26'h1, 2'b01);
        do_snoop(32'h50, 1'b1, 0, 1'b0, 0);
        @(negedge CLK);
        chk("stats_hits", {16'd0, snoop_hits}, m_hits);
        chk("stats_wbs", {16'd0, snoop_wbs}, m_wbs);
`endif

        repeat (4) @(posedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
